spi_wb_bridge: RTL

- Wishbone B4 classic master directly downstream of the SPI slave front end.
- Takes the decoded request (wrn, select, 19-bit byte address, write data, start pulse) from the SPI serial-clock domain into the system clock domain and runs exactly one Wishbone cycle per request.
- Returns read data on a stable bus that the SPI slave shifts out on MISO.
- Clocked by the system clock only; all SPI-domain inputs are treated as asynchronous.

---
 rtl/spi_wb_pkg.sv | 30 +++
 rtl/spi_wb_bridge_sync_2ff_edge.sv | 33 +++
 rtl/spi_wb_bridge.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/spi_wb_pkg.sv
// Shared types and helpers for the SPI-to-Wishbone bridge.
// Select-lane encodings, FSM states and the read-lane mask.
package spi_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CYCLE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] WB_FULL_WORD       = 4'hF;
    localparam logic [3:0] WB_UPPER_HALF_WORD = 4'hC;
    localparam logic [3:0] WB_LOWER_HALF_WORD = 4'h3;
    localparam logic [3:0] WB_BYTE_0          = 4'h1;
    localparam logic [3:0] WB_BYTE_1          = 4'h2;
    localparam logic [3:0] WB_BYTE_2          = 4'h4;
    localparam logic [3:0] WB_BYTE_3          = 4'h8;

    localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/spi_wb_bridge_sync_2ff_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// pulse_o is a single clk-cycle pulse per synchronized rising edge.
module sync_2ff_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulse_o
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d_i;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/spi_wb_bridge.sv
// Wishbone B4 classic master fed by the SPI slave request bus.
// Optional cycle timeout: define SPI_WB_BRIDGE_TIMEOUT_EN.
module spi_wb_bridge
  import spi_wb_pkg::*;
#(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              spi_start_i,
  input  logic              spi_wrn_i,
  input  logic [3:0]        spi_select_i,
  input  logic [ADDR_W-1:0] spi_address_i,
  input  logic [DATA_W-1:0] spi_data_i,
  output logic [DATA_W-1:0] spi_rd_data_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic              busy_o,
  output logic              err_o,
  output logic              overrun_o
);

  logic req_pulse;

  sync_2ff_edge u_start_sync (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .d_i     (spi_start_i),
    .pulse_o (req_pulse)
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic              cyc_q, cyc_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;

`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W =
    ($clog2(TIMEOUT_CYC + 1) > 8) ?
    $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rd_d    = rd_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    if (req_pulse && state_q != IDLE) begin
      ovr_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (req_pulse) begin
          adr_d   = spi_address_i;
          dat_d   = spi_data_i;
          sel_d   = spi_select_i;
          we_d    = spi_wrn_i;
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = CYCLE;
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      CYCLE: begin
        if (wb_err_i) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rd_d = '0;
          end
        end else if (wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rd_d = wb_dat_i & lane_mask(sel_q);
          end
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rd_d = TIMEOUT_PATTERN & lane_mask(sel_q);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      rd_q    <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rd_q    <= rd_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign spi_rd_data_o = rd_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign wb_we_o       = we_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign overrun_o     = ovr_q;

endmodule
